// File: rtl/dlyc_cal_pkg.sv
// Shared definitions for the delay-line tap calibration sequencer.
//   state_e      : sequencer states
//   DEF_*        : default parameter values
//   maj_thr()    : smallest vote count v with 2*v > nsamp
//   max_u()      : unsigned maximum, used for counter sizing
package dlyc_cal_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    EVAL   = 2'd3
  } state_e;

  localparam int unsigned DEF_TAP_W      = 5;
  localparam int unsigned DEF_SETTLE_CYC = 4;
  localparam int unsigned DEF_NSAMP      = 8;

  // 2*v > n  <=>  v >= floor(n/2) + 1, so a tie is never late.
  function automatic int unsigned maj_thr(input int unsigned nsamp);
    return (nsamp / 2) + 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dlyc_cal_vote.sv
// PD_LATE majority vote counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the vote count (priority over en)
//   en       : count vote_in this cycle
//   vote_in  : phase detector sample
//   late     : registered flag, 1 when the accumulated count is a strict majority of NSAMP
module dlyc_cal_vote
  import dlyc_cal_pkg::*;
#(
  parameter int unsigned NSAMP = DEF_NSAMP
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic vote_in,
  output logic late
);

  localparam int unsigned          VOTE_W = $clog2(NSAMP + 1);
  localparam logic [VOTE_W-1:0]    THR    = VOTE_W'(maj_thr(NSAMP));

  logic [VOTE_W-1:0] cnt_q, cnt_d;
  logic              late_q, late_d;

  // The flag is computed from the next count so it is valid in the cycle
  // right after the last sample.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && vote_in) begin
      cnt_d = cnt_q + VOTE_W'(1);
    end
    late_d = (cnt_d >= THR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      late_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      late_q <= late_d;
    end
  end

  assign late = late_q;

endmodule

// File: rtl/dlyc_tap_cal_ctrl.sv
// Tapped delay-line calibration sequencer: sweeps the tap select upward from
// 0 and locks on the first tap judged late by majority vote of PD_LATE.
//   CLK, RST  : clock, synchronous active-high reset
//   START     : begin calibration (IDLE only, OVR_EN=0)
//   ABORT     : cancel a calibration in progress
//   PD_LATE   : phase detector, 1 = delayed edge is late
//   OVR_EN    : software override enable, OVR_TAP drives TAP
//   TAP       : registered tap select
//   BUSY      : calibration in progress
//   DONE/LOCKED/ERR : sticky result flags, cleared by START, ABORT, RST
module dlyc_tap_cal_ctrl
  import dlyc_cal_pkg::*;
#(
  parameter int unsigned TAP_W      = DEF_TAP_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned NSAMP      = DEF_NSAMP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             PD_LATE,
  input  logic             OVR_EN,
  input  logic [TAP_W-1:0] OVR_TAP,
  output logic [TAP_W-1:0] TAP,
  output logic             BUSY,
  output logic             DONE,
  output logic             LOCKED,
  output logic             ERR
);

  localparam int unsigned       CNT_W       = $clog2(max_u(SETTLE_CYC, NSAMP) + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(NSAMP - 1);

  state_e             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic               vote_clr, vote_en, late;

  logic busy;
  assign busy = (state_q != IDLE);

  // Votes accumulate only in SAMPLE; the counter is held clear in IDLE and
  // EVAL so each tap (and each fresh calibration) starts from zero.
  assign vote_en  = (state_q == SAMPLE);
  assign vote_clr = (state_q == IDLE) || (state_q == EVAL);

  dlyc_cal_vote #(
    .NSAMP (NSAMP)
  ) u_vote (
    .clk     (CLK),
    .rst     (RST),
    .clr     (vote_clr),
    .en      (vote_en),
    .vote_in (PD_LATE),
    .late    (late)
  );

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    locked_d = locked_q;
    err_d    = err_q;

    if (OVR_EN) begin
      // Override entered while busy behaves as an abort for the flags.
      state_d = IDLE;
      tap_d   = OVR_TAP;
      cnt_d   = '0;
      if (busy) begin
        done_d   = 1'b0;
        locked_d = 1'b0;
        err_d    = 1'b0;
      end
    end else if (ABORT && busy) begin
      state_d  = IDLE;
      tap_d    = '0;
      cnt_d    = '0;
      done_d   = 1'b0;
      locked_d = 1'b0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (START) begin
            state_d  = SETTLE;
            tap_d    = '0;
            cnt_d    = '0;
            done_d   = 1'b0;
            locked_d = 1'b0;
            err_d    = 1'b0;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SAMPLE: begin
          if (cnt_q == SAMPLE_LAST) begin
            cnt_d   = '0;
            state_d = EVAL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        EVAL: begin
          cnt_d = '0;
          if (late) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (tap_q != '0) begin
              locked_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (tap_q == '1) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = SETTLE;
            tap_d   = tap_q + TAP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      tap_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign TAP    = tap_q;
  assign BUSY   = busy;
  assign DONE   = done_q;
  assign LOCKED = locked_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_dlyc_tap_cal_ctrl.sv
// Directed testbench for dlyc_tap_cal_ctrl at default parameters.
// Observed status word is {BUSY, DONE, LOCKED, ERR, TAP[4:0]}.
// Cycle n is the clock period following the edge that sampled START (n=1 first).
module tb_dlyc_tap_cal_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       ABORT;
  logic       PD_LATE;
  logic       OVR_EN;
  logic [4:0] OVR_TAP;
  logic [4:0] TAP;
  logic       BUSY, DONE, LOCKED, ERR;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_st;

  always #5 CLK = ~CLK;

  dlyc_tap_cal_ctrl #(
    .TAP_W      (5),
    .SETTLE_CYC (4),
    .NSAMP      (8)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .ABORT   (ABORT),
    .PD_LATE (PD_LATE),
    .OVR_EN  (OVR_EN),
    .OVR_TAP (OVR_TAP),
    .TAP     (TAP),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .LOCKED  (LOCKED),
    .ERR     (ERR)
  );

  function automatic logic [8:0] obs();
    return {BUSY, DONE, LOCKED, ERR, TAP};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; PD_LATE = 1'b0;
    OVR_EN = 1'b0; OVR_TAP = 5'd0;
    tick(); tick();
    n_checks++;
    if (obs() !== 9'b0) begin
      n_fail++; $display("FAIL reset_held: got %b want %b", obs(), 9'b0);
    end
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (obs() !== 9'b0) begin
        n_fail++; $display("FAIL reset_idle_%0d: got %b want %b", i, obs(), 9'b0);
      end
    end
  endtask

  // PD_LATE = (TAP >= 5); a START pulse in cycle 20 must be ignored.
  task automatic test_normal_lock();
    PD_LATE = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 1; c <= 79; c++) begin
      if (c > 1) tick();
      if (c == 79) begin
        exp_st = {1'b0, 1'b1, 1'b1, 1'b0, 5'd5};
        n_checks++;
        if (obs() !== exp_st) begin
          n_fail++; $display("FAIL lock_c79: got %b want %b", obs(), exp_st);
        end
      end else if ((c - 1) % 13 == 0) begin
        exp_st = {1'b1, 3'b000, 5'((c - 1) / 13)};
        n_checks++;
        if (obs() !== exp_st) begin
          n_fail++; $display("FAIL lock_step_c%0d: got %b want %b", c, obs(), exp_st);
        end
      end
      PD_LATE = (TAP >= 5'd5);
      START   = (c == 20);
    end
    START = 1'b0; PD_LATE = 1'b0;
    tick();
  endtask

  task automatic test_late_at_zero();
    PD_LATE = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    exp_st = {1'b1, 3'b000, 5'd0};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL late0_c1: got %b want %b", obs(), exp_st);
    end
    for (int c = 2; c <= 14; c++) tick();
    exp_st = {1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL late0_c14: got %b want %b", obs(), exp_st);
    end
    PD_LATE = 1'b0;
  endtask

  task automatic test_never_late();
    PD_LATE = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 2; c <= 416; c++) tick();
    exp_st = {1'b1, 3'b000, 5'd31};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL never_c416: got %b want %b", obs(), exp_st);
    end
    tick();
    exp_st = {1'b0, 1'b1, 1'b0, 1'b1, 5'd31};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL never_c417: got %b want %b", obs(), exp_st);
    end
    tick(); tick(); tick();
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL never_hold: got %b want %b", obs(), exp_st);
    end
  endtask

  // 4/8 votes (tie) at taps 0..2, 5/8 at tap 3; PD_LATE also high during
  // SETTLE and EVAL, where it must not count.
  task automatic test_majority_tie();
    int pos, k, nv;
    PD_LATE = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 1; c <= 53; c++) begin
      if (c > 1) tick();
      if (c == 27 || c == 40) begin
        exp_st = {1'b1, 3'b000, 5'((c - 1) / 13)};
        n_checks++;
        if (obs() !== exp_st) begin
          n_fail++; $display("FAIL tie_step_c%0d: got %b want %b", c, obs(), exp_st);
        end
      end else if (c == 53) begin
        exp_st = {1'b0, 1'b1, 1'b1, 1'b0, 5'd3};
        n_checks++;
        if (obs() !== exp_st) begin
          n_fail++; $display("FAIL tie_lock_c53: got %b want %b", obs(), exp_st);
        end
      end
      pos = (c - 1) % 13;
      k   = (c - 1) / 13;
      nv  = (k == 3) ? 5 : 4;
      PD_LATE = (pos < 4) || (pos == 12) || (pos >= 4 && pos < 12 && (pos - 4) < nv);
    end
    PD_LATE = 1'b0;
    tick();
  endtask

  task automatic test_abort_start();
    PD_LATE = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 2; c <= 30; c++) tick();
    exp_st = {1'b1, 3'b000, 5'd2};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL abort_pre_c30: got %b want %b", obs(), exp_st);
    end
    ABORT = 1'b1; START = 1'b1;
    tick();
    ABORT = 1'b0; START = 1'b0;
    n_checks++;
    if (obs() !== 9'b0) begin
      n_fail++; $display("FAIL abort_collide: got %b want %b", obs(), 9'b0);
    end
    tick();
    n_checks++;
    if (obs() !== 9'b0) begin
      n_fail++; $display("FAIL abort_stays_idle: got %b want %b", obs(), 9'b0);
    end
    START = 1'b1;
    tick();
    START = 1'b0;
    exp_st = {1'b1, 3'b000, 5'd0};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL restart_c1: got %b want %b", obs(), exp_st);
    end
    for (int c = 2; c <= 14; c++) tick();
    exp_st = {1'b1, 3'b000, 5'd1};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL restart_c14: got %b want %b", obs(), exp_st);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_abort_idle();
    PD_LATE = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 2; c <= 14; c++) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    exp_st = {1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL abort_in_idle: got %b want %b", obs(), exp_st);
    end
    ABORT = 1'b1; START = 1'b1;
    tick();
    ABORT = 1'b0; START = 1'b0;
    exp_st = {1'b1, 3'b000, 5'd0};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL start_abort_idle: got %b want %b", obs(), exp_st);
    end
    for (int c = 2; c <= 14; c++) tick();
    PD_LATE = 1'b0;
  endtask

  task automatic test_override();
    // Idle with DONE/ERR set: override must leave the flags alone.
    OVR_EN = 1'b1; OVR_TAP = 5'd17;
    tick();
    exp_st = {1'b0, 1'b1, 1'b0, 1'b1, 5'd17};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL ovr_idle: got %b want %b", obs(), exp_st);
    end
    OVR_TAP = 5'd9; START = 1'b1;
    tick();
    START = 1'b0;
    exp_st = {1'b0, 1'b1, 1'b0, 1'b1, 5'd9};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL ovr_follow_start_ign: got %b want %b", obs(), exp_st);
    end
    OVR_EN = 1'b0;
    tick();
    PD_LATE = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 2; c <= 20; c++) tick();
    exp_st = {1'b1, 3'b000, 5'd1};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL ovr_pre_c20: got %b want %b", obs(), exp_st);
    end
    OVR_EN = 1'b1; OVR_TAP = 5'd17;
    tick();
    exp_st = {1'b0, 3'b000, 5'd17};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL ovr_busy: got %b want %b", obs(), exp_st);
    end
    START = 1'b1;
    tick();
    START = 1'b0;
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL ovr_start_ign: got %b want %b", obs(), exp_st);
    end
    OVR_EN = 1'b0; OVR_TAP = 5'd3;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL ovr_release_hold: got %b want %b", obs(), exp_st);
    end
  endtask

  task automatic test_reset_mid_sweep();
    PD_LATE = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 2; c <= 40; c++) tick();
    exp_st = {1'b1, 3'b000, 5'd3};
    n_checks++;
    if (obs() !== exp_st) begin
      n_fail++; $display("FAIL rst_pre_c40: got %b want %b", obs(), exp_st);
    end
    RST = 1'b1;
    tick();
    n_checks++;
    if (obs() !== 9'b0) begin
      n_fail++; $display("FAIL rst_mid: got %b want %b", obs(), 9'b0);
    end
    RST = 1'b0;
    tick(); tick();
    n_checks++;
    if (obs() !== 9'b0) begin
      n_fail++; $display("FAIL rst_after: got %b want %b", obs(), 9'b0);
    end
  endtask

  initial begin
    test_reset();
    test_normal_lock();
    test_late_at_zero();
    test_never_late();
    test_majority_tie();
    test_abort_start();
    test_abort_idle();
    test_override();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
